// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
//
// Ports (as seen from the slave, i.e. the adder):
//   in_valid   in   operands present
//   in_ready   out  adder accepts operands this cycle
//   op_a/op_b  in   W-bit operands
//   cin_in     in   carry into nibble 0
//   out_valid  out  result/cout_out valid
//   out_ready  in   consumer accepts result
//   result     out  W-bit registered sum
//   cout_out   out  carry out of the top nibble
//   busy       out  operation in flight or awaiting pickup
interface nibble_serial_adder_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout_out;
    logic         busy;

    modport master (
        output in_valid, op_a, op_b, cin_in, out_ready,
        input  in_ready, out_valid, result, cout_out, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin_in, out_ready,
        output in_ready, out_valid, result, cout_out, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-word adder feeding one 4-bit CLA slice per clock
//
// fourbitfulladderNonRipple: combinational 4-bit carry-lookahead adder.
//   a, b (4b), cin -> sum (4b), cout
//
// nibble_serial_adder: computes op_a + op_b + cin_in over NIBBLES clocks.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  nibble_serial_adder_if.slave (input and output valid/ready handshakes)

module fourbitfulladderNonRipple (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/cin, no chained carries.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            cy_q, cy_d;
    logic            cout_q, cout_d;

    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [3:0]      slice_sum;
    logic            slice_cout;
    logic            last_nibble;

    // Shift the current nibble down to bit 0 so the slice always sees [3:0].
    assign a_sh        = a_q >> {idx_q, 2'b00};
    assign b_sh        = b_q >> {idx_q, 2'b00};
    assign last_nibble = (idx_q == IDXW'(NIBBLES - 1));

    fourbitfulladderNonRipple u_slice (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (cy_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    cy_d    = bus.cin_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        result_d[4*n +: 4] = slice_sum;
                    end
                end
                cy_d  = slice_cout;
                idx_d = idx_q + IDXW'(1);
                if (last_nibble) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Result is held until the consumer takes it; no new operand
                // is accepted on the same edge.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout_out  = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (NIBBLES=4 and 1)
module tb_nibble_serial_adder;
    localparam int N4 = 4;
    localparam int W4 = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    nibble_serial_adder_if #(.W(W4)) bus4 ();
    nibble_serial_adder_if #(.W(4))  bus1 ();

    nibble_serial_adder #(.NIBBLES(N4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: the true (W+1)-bit sum.
    function automatic logic [W4:0] ref_sum(input logic [W4-1:0] a, input logic [W4-1:0] b,
                                            input logic cin);
        ref_sum = {1'b0, a} + {1'b0, b} + {{W4{1'b0}}, cin};
    endfunction

    // Drive one operation on the 16-bit DUT up to out_valid; operands are
    // scrambled right after acceptance. Leaves the DUT in DONE.
    task automatic start_and_wait(input logic [W4-1:0] a, input logic [W4-1:0] b,
                                  input logic cin, output int lat);
        bus4.in_valid = 1'b1;
        bus4.op_a     = a;
        bus4.op_b     = b;
        bus4.cin_in   = cin;
        cyc();
        bus4.in_valid = 1'b0;
        bus4.op_a     = W4'($urandom);
        bus4.op_b     = W4'($urandom);
        bus4.cin_in   = 1'($urandom);
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            cyc();
            lat++;
        end
    endtask

    task automatic take_result();
        bus4.out_ready = 1'b1;
        cyc();
        bus4.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%b ov=%b busy=%b want 1 0 0",
                     bus4.in_ready, bus4.out_valid, bus4.busy);
        end
        checks++;
        if (bus4.result !== 16'h0 || bus4.cout_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got res=%h co=%b want 0000 0", bus4.result, bus4.cout_out);
        end
    endtask

    task automatic test_directed();
        logic [W4-1:0] va[3] = '{16'h1234, 16'hFFFF, 16'h8000};
        logic [W4-1:0] vb[3] = '{16'h0FCD, 16'h0001, 16'h8000};
        logic          vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W4:0]   exp;
        int            lat;
        for (int i = 0; i < 3; i++) begin
            exp = ref_sum(va[i], vb[i], vc[i]);
            start_and_wait(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== N4) begin
                failures++;
                $display("FAIL directed_lat[%0d] got=%0d want=%0d", i, lat, N4);
            end
            checks++;
            if ({bus4.cout_out, bus4.result} !== exp) begin
                failures++;
                $display("FAIL directed_sum[%0d] got=%b_%h want=%b_%h", i,
                         bus4.cout_out, bus4.result, exp[W4], exp[W4-1:0]);
            end
            take_result();
        end
    endtask

    task automatic test_random();
        logic [W4-1:0] a;
        logic [W4-1:0] b;
        logic          c;
        logic [W4:0]   exp;
        int            lat;
        for (int i = 0; i < 25; i++) begin
            a = W4'($urandom);
            b = W4'($urandom);
            c = 1'($urandom);
            exp = ref_sum(a, b, c);
            start_and_wait(a, b, c, lat);
            checks++;
            if (lat !== N4 || {bus4.cout_out, bus4.result} !== exp) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h c=%b got lat=%0d %b_%h want lat=%0d %b_%h",
                         i, a, b, c, lat, bus4.cout_out, bus4.result, N4, exp[W4], exp[W4-1:0]);
            end
            take_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [W4:0] exp;
        int          lat;
        start_and_wait(16'h8000, 16'h8000, 1'b1, lat);
        checks++;
        if ({bus4.cout_out, bus4.result} !== 17'h1_0001) begin
            failures++;
            $display("FAIL b2b_first got=%b_%h want=1_0001", bus4.cout_out, bus4.result);
        end
        // Present the next operands during the output handshake.
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.op_a      = 16'h0003;
        bus4.op_b      = 16'h0002;
        bus4.cin_in    = 1'b0;
        cyc();
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got rdy=%b ov=%b want 1 0", bus4.in_ready, bus4.out_valid);
        end
        cyc();
        bus4.in_valid = 1'b0;
        checks++;
        if (bus4.busy !== 1'b1 || bus4.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b rdy=%b want 1 0", bus4.busy, bus4.in_ready);
        end
        exp = ref_sum(16'h0003, 16'h0002, 1'b0);
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            cyc();
            lat++;
        end
        checks++;
        if (lat !== N4 || {bus4.cout_out, bus4.result} !== exp) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d %b_%h want lat=%0d %b_%h",
                     lat, bus4.cout_out, bus4.result, N4, exp[W4], exp[W4-1:0]);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        logic [W4:0] exp;
        int          lat;
        int          bad;
        exp = ref_sum(16'hA5C3, 16'h5A4D, 1'b1);
        start_and_wait(16'hA5C3, 16'h5A4D, 1'b1, lat);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus4.in_valid = 1'($urandom);
            bus4.op_a     = W4'($urandom);
            bus4.op_b     = W4'($urandom);
            bus4.cin_in   = 1'($urandom);
            cyc();
            if ({bus4.cout_out, bus4.result} !== exp || bus4.in_ready !== 1'b0
                || bus4.out_valid !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold got %0d bad cycles res=%b_%h want 0 bad %b_%h",
                     bad, bus4.cout_out, bus4.result, exp[W4], exp[W4-1:0]);
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        cyc();
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release got ov=%b rdy=%b busy=%b want 0 1 0",
                     bus4.out_valid, bus4.in_ready, bus4.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus4.in_valid = 1'b1;
        bus4.op_a     = 16'hFFFF;
        bus4.op_b     = 16'h0001;
        bus4.cin_in   = 1'b0;
        cyc();
        bus4.in_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0
            || bus4.result !== 16'h0 || bus4.cout_out !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got ov=%b rdy=%b busy=%b res=%h co=%b want 0 1 0 0000 0",
                     bus4.out_valid, bus4.in_ready, bus4.busy, bus4.result, bus4.cout_out);
        end
        start_and_wait(16'h0001, 16'h0001, 1'b0, lat);
        checks++;
        if (lat !== N4 || {bus4.cout_out, bus4.result} !== 17'h0_0002) begin
            failures++;
            $display("FAIL midrun_after got lat=%0d %b_%h want lat=4 0_0002",
                     lat, bus4.cout_out, bus4.result);
        end
        take_result();
    endtask

    task automatic test_nib1();
        logic [4:0] exp;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 4'hF;
                b = 4'h1;
                c = 1'b1;
            end else begin
                a = 4'($urandom);
                b = 4'($urandom);
                c = 1'($urandom);
            end
            exp = {1'b0, a} + {1'b0, b} + {4'b0, c};
            bus1.in_valid = 1'b1;
            bus1.op_a     = a;
            bus1.op_b     = b;
            bus1.cin_in   = c;
            cyc();
            bus1.in_valid = 1'b0;
            bus1.op_a     = 4'($urandom);
            lat = 0;
            while (!bus1.out_valid && lat < 10) begin
                cyc();
                lat++;
            end
            checks++;
            if (lat !== 1 || {bus1.cout_out, bus1.result} !== exp) begin
                failures++;
                $display("FAIL nib1[%0d] a=%h b=%h c=%b got lat=%0d %b_%h want lat=1 %b_%h",
                         i, a, b, c, lat, bus1.cout_out, bus1.result, exp[4], exp[3:0]);
            end
            bus1.out_ready = 1'b1;
            cyc();
            bus1.out_ready = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.op_a      = '0;
        bus4.op_b      = '0;
        bus4.cin_in    = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.op_a      = '0;
        bus1.op_b      = '0;
        bus1.cin_in    = 1'b0;
        bus1.out_ready = 1'b0;

        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_nib1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
